// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: sizing helpers, byte/word
// transforms and the expansion engine state encoding.
package aes_pkg;

    localparam int NB = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Number of cipher rounds for a key of nk 32-bit words.
    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    // Total schedule words: one 4-word round key per round plus the initial one.
    function automatic int words_of(input int nk);
        return 4 * (nr_of(nk) + 1);
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Rotate a word left by one byte: (a,b,c,d) -> (b,c,d,a), a in the MSBs.
    function automatic logic [31:0] rotword(input logic [31:0] a);
        return {a[23:0], a[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box as a constant lookup table.
module aes_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_out = SBOX[i_in];

endmodule

// File: rtl/key_expand_seq.sv
// Sequential AES key-schedule engine: produces one schedule word per clock
// into a register array and serves round keys through a registered read port.
module key_expand_seq #(
    parameter int NK = 8,
    parameter int NR = 14,
    parameter int NB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NK*32-1:0]  key,
    output logic              busy,
    output logic              done,
    input  logic [3:0]        rk_idx,
    output logic [127:0]      rk
);
    import aes_pkg::*;

    localparam int WORDS = words_of(NK);

    if (!((NK == 4) || (NK == 6) || (NK == 8)) || (NR != nr_of(NK)) || (NB != aes_pkg::NB)) begin : g_param_check
        $error("key_expand_seq: NK must be 4/6/8, NR must equal NK+6, NB must be 4");
    end

    state_t         r_state;
    state_t         w_next_state;
    logic [5:0]     r_i;
    logic [2:0]     r_j;
    logic [7:0]     r_rcon;
    logic [127:0]   r_rk;
    logic [31:0]    r_wmem [WORDS];

    logic           w_accept;
    logic           w_last;
    logic [31:0]    w_prev;
    logic [31:0]    w_back;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [31:0]    w_temp;
    logic [31:0]    w_new;
    logic [5:0]     w_rd_base;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_i == 6'(WORDS - 1));
    assign w_prev   = r_wmem[r_i - 6'd1];
    assign w_back   = r_wmem[r_i - 6'(NK)];
    assign w_sub_in = (r_j == 3'd0) ? rotword(w_prev) : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .i_in  (w_sub_in[8*b +: 8]),
            .o_out (w_sub_out[8*b +: 8])
        );
    end

    // Pick the schedule transform for this word from the phase counter.
    always_comb begin
        w_temp = w_prev;
        if (r_j == 3'd0) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h0};
        end else if ((NK == 8) && (r_j == 3'd4)) begin
            w_temp = w_sub_out;
        end
    end

    assign w_new = w_back ^ w_temp;

    // State register; reset always wins over a simultaneous start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: start restarts from IDLE or DONE, expansion ends on the last word.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next_state = EXPAND;
            EXPAND:     if (w_last) w_next_state = DONE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Status outputs decoded purely from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            EXPAND:  busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Word index, NK-phase counter and round constant advance once per generated word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i    <= '0;
            r_j    <= '0;
            r_rcon <= 8'h01;
        end else if (w_accept) begin
            r_i    <= 6'(NK);
            r_j    <= '0;
            r_rcon <= 8'h01;
        end else if (r_state == EXPAND) begin
            r_i <= r_i + 6'd1;
            r_j <= (r_j == 3'(NK - 1)) ? 3'd0 : r_j + 3'd1;
            if (r_j == 3'd0) begin
                r_rcon <= xtime(r_rcon);
            end
        end
    end

    // Schedule storage: key words load on accept, then one new word per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_accept) begin
                for (int k = 0; k < NK; k++) begin
                    r_wmem[k] <= key[(NK-1-k)*32 +: 32];
                end
            end else if (r_state == EXPAND) begin
                r_wmem[r_i] <= w_new;
            end
        end
    end

    assign w_rd_base = {rk_idx, 2'b00};

    // Registered round-key read; out-of-range indices return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rk <= '0;
        end else if (rk_idx > 4'(NR)) begin
            r_rk <= '0;
        end else begin
            r_rk <= {r_wmem[w_rd_base], r_wmem[w_rd_base + 6'd1],
                     r_wmem[w_rd_base + 6'd2], r_wmem[w_rd_base + 6'd3]};
        end
    end

    assign rk = r_rk;

endmodule
